// File: rtl/alu_issue_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, instruction
// field positions, FSM encoding and the opcode decode helpers.
package alu_issue_sequencer_pkg;

    localparam logic [7:0] OP_ADD = 8'h88;
    localparam logic [7:0] OP_SUB = 8'h89;
    localparam logic [7:0] OP_INC = 8'h8A;

    // Instruction layout: [31:24] opcode, [15:8] operand 2, [7:0] operand 1
    localparam int OPC_LSB = 24;
    localparam int OP2_LSB = 8;
    localparam int OP1_LSB = 0;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        F_ADD = 2'd0,
        F_SUB = 2'd1,
        F_INC = 2'd2
    } func_t;

    // Unknown opcodes fall back to add (and get flagged separately)
    function automatic func_t op_func(input logic [7:0] opc);
        case (opc)
            OP_SUB:  return F_SUB;
            OP_INC:  return F_INC;
            default: return F_ADD;
        endcase
    endfunction

    function automatic logic op_bad(input logic [7:0] opc);
        return !(opc == OP_ADD || opc == OP_SUB || opc == OP_INC);
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous DEPTH x WIDTH instruction queue. Push while full and pop
// while empty are ignored; simultaneous push/pop keeps count unchanged.
module alu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: nothing is read until count says it is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer: queues instructions, steps each through DECODE, EXEC
// and DONE, and hands results off on a valid/ready port.
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        instr_in,
    output logic               instr_ready,
    output logic               result_valid,
    output logic [7:0]         result,
    output logic [7:0]         res_op,
    output logic               bad_op,
    input  logic               result_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   retired
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t              state;
    state_t              state_nxt;
    logic                pop;
    logic                push;
    logic                q_empty;
    logic                q_full;
    logic [CW-1:0]       q_count;
    logic [INSTR_W-1:0]  q_head;

    logic [INSTR_W-1:0]  ir;
    func_t               func;
    logic [7:0]          op1;
    logic [7:0]          op2;
    logic [7:0]          opc;
    logic                bad_r;
    logic [7:0]          alu_out;
    logic                unused_ir;

    // Bits [23:16] of the instruction carry nothing
    assign unused_ir = &{1'b0, ir[23:16]};

    // instr_ready comes only from the registered queue count
    assign instr_ready = !q_full;
    assign push        = instr_valid && instr_ready;
    assign busy        = (state != S_IDLE) || (q_count != '0);

    alu_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (instr_in),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE goes straight to DECODE when work is queued
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!q_empty) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_DONE;
            S_DONE:   if (result_ready) state_nxt = q_empty ? S_IDLE : S_DECODE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: queue pop and result valid
    always_comb begin
        pop          = 1'b0;
        result_valid = (state == S_DONE);
        case (state)
            S_IDLE:  pop = !q_empty;
            S_DONE:  pop = result_ready && !q_empty;
            default: pop = 1'b0;
        endcase
    end

    // ALU: 8-bit, carry/borrow dropped
    always_comb begin
        alu_out = op1 + op2;
        case (func)
            F_SUB:   alu_out = op1 - op2;
            F_INC:   alu_out = op1 + 8'd1;
            default: alu_out = op1 + op2;
        endcase
    end

    // Datapath registers: instruction, decoded operands, result, counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            func    <= F_ADD;
            op1     <= '0;
            op2     <= '0;
            opc     <= '0;
            bad_r   <= 1'b0;
            result  <= '0;
            res_op  <= '0;
            bad_op  <= 1'b0;
            retired <= '0;
        end else begin
            if (pop) ir <= q_head;
            if (state == S_DECODE) begin
                opc   <= ir[OPC_LSB +: 8];
                op1   <= ir[OP1_LSB +: 8];
                op2   <= ir[OP2_LSB +: 8];
                func  <= op_func(ir[OPC_LSB +: 8]);
                bad_r <= op_bad(ir[OPC_LSB +: 8]);
            end
            // Result fields only change on entry to DONE, so they hold while valid
            if (state == S_EXEC) begin
                result <= alu_out;
                res_op <= opc;
                bad_op <= bad_r;
            end
            if (result_valid && result_ready) retired <= retired + CNT_W'(1);
        end
    end

endmodule
